// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO: requester ids, arbiter states and
// Gray/binary pointer conversion.
package fifo_pkg;

  localparam int unsigned NUM_REQ   = 2;
  localparam int unsigned REQ_APB   = 0;
  localparam int unsigned REQ_I2C   = 1;
  localparam int unsigned PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  // Preferred requester when both request in the same cycle.
  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } arb_state_t;

  // Width-generic: callers zero-extend into ptr_word_t and truncate the result.
  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_read_arbiter_rr.sv
// Two-requester round-robin arbiter for the FIFO read port; state remembers
// which requester is preferred after the last granted read.
module rr_arbiter_2
  import fifo_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               fire,
  output logic [NUM_REQ-1:0] grant
);

  arb_state_t state;
  arb_state_t state_next;

  // State register; reset prefers the APB path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PRI0;
    end else begin
      state <= state_next;
    end
  end

  // Grant selection; the winner hands priority to the other requester.
  always_comb begin
    state_next = state;
    grant      = '0;
    if (fire) begin
      if (req[REQ_APB] && req[REQ_I2C]) begin
        if (state == PRI0) grant[REQ_APB] = 1'b1;
        else               grant[REQ_I2C] = 1'b1;
      end else begin
        grant = req;
      end
      state_next = grant[REQ_APB] ? PRI1 : PRI0;
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Read-domain controller of the async FIFO: read pointers, registered empty flag
// and shared read port. Optional READ_LEVEL_EN adds a registered fill-level output.
module fifo_read_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned address_size = 3,
  parameter int unsigned data_width   = 8
) (
  input  logic                    read_clk,
  input  logic                    read_reset_n,
  input  logic [address_size:0]   read_to_write_pointer,
  input  logic [data_width-1:0]   mem_read_data,
  input  logic [NUM_REQ-1:0]      req,
  output logic [address_size-1:0] read_address,
  output logic [address_size:0]   read_pointer,
  output logic                    empty,
  output logic [NUM_REQ-1:0]      grant,
  output logic [data_width-1:0]   data_out,
  output logic [NUM_REQ-1:0]      data_valid
`ifdef READ_LEVEL_EN
  ,
  output logic [address_size:0]   read_level
`endif
);

  localparam int unsigned PTR_W = address_size + 1;

  logic [PTR_W-1:0] read_bin;
  logic [PTR_W-1:0] read_bin_next;
  logic [PTR_W-1:0] read_gray_next;
  logic             read_fire;

  assign read_fire      = (req != '0) && !empty;
  assign read_bin_next  = read_bin + PTR_W'(read_fire);
  assign read_gray_next = PTR_W'(bin2gray(PTR_MAX_W'(read_bin_next)));
  assign read_address   = read_bin[address_size-1:0];

  rr_arbiter_2 u_arb (
    .clk   (read_clk),
    .rst_n (read_reset_n),
    .req   (req),
    .fire  (read_fire),
    .grant (grant)
  );

  // Full Gray comparison keeps the wrap bit, so empty is unambiguous across laps.
  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      read_bin     <= '0;
      read_pointer <= '0;
      empty        <= 1'b1;
      data_out     <= '0;
      data_valid   <= '0;
    end else begin
      read_bin     <= read_bin_next;
      read_pointer <= read_gray_next;
      empty        <= (read_gray_next == read_to_write_pointer);
      data_valid   <= grant;
      if (read_fire) begin
        data_out <= mem_read_data;
      end
    end
  end

`ifdef READ_LEVEL_EN
  logic [PTR_W-1:0] write_bin_sync;

  assign write_bin_sync = PTR_W'(gray2bin(PTR_MAX_W'(read_to_write_pointer)));

  // Lags the real write pointer by the synchronizer, so it can only under-report.
  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      read_level <= '0;
    end else begin
      read_level <= write_bin_sync - read_bin_next;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Self-checking bench for fifo_read_arbiter: cycle model plus a read-data
// scoreboard; define READ_LEVEL_EN to also cover read_level.
module tb_fifo_read_arbiter;

  logic       read_clk = 1'b0;
  logic       read_reset_n;
  logic [3:0] read_to_write_pointer;
  logic [7:0] mem_read_data;
  logic [1:0] req;
  logic [2:0] read_address;
  logic [3:0] read_pointer;
  logic       empty;
  logic [1:0] grant;
  logic [7:0] data_out;
  logic [1:0] data_valid;
`ifdef READ_LEVEL_EN
  logic [3:0] read_level;
  logic [3:0] exp_level;
`endif

  logic [7:0] mem [8];
  assign mem_read_data = mem[read_address];

  always #5 read_clk = ~read_clk;

  fifo_read_arbiter #(.address_size(3), .data_width(8)) dut (
    .read_clk              (read_clk),
    .read_reset_n          (read_reset_n),
    .read_to_write_pointer (read_to_write_pointer),
    .mem_read_data         (mem_read_data),
    .req                   (req),
    .read_address          (read_address),
    .read_pointer          (read_pointer),
    .empty                 (empty),
    .grant                 (grant),
    .data_out              (data_out),
    .data_valid            (data_valid)
`ifdef READ_LEVEL_EN
    ,
    .read_level            (read_level)
`endif
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } sb_t;

  sb_t sb[$];
  int  checks   = 0;
  int  failures = 0;

  logic [3:0] m_bin;
  logic       m_empty;
  logic       m_pref;
  logic       prev_fire;
  logic [1:0] exp_grant;
  logic [1:0] exp_dv;
  logic [7:0] exp_dout;

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ {1'b0, b[3:1]};
  endfunction

  function automatic logic [3:0] from_gray(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  task automatic model_reset();
    m_bin = 4'd0; m_empty = 1'b1; m_pref = 1'b0; prev_fire = 1'b0;
    exp_grant = 2'b00; exp_dv = 2'b00; exp_dout = 8'h00;
    sb.delete();
`ifdef READ_LEVEL_EN
    exp_level = 4'd0;
`endif
  endtask

  // Advance one clock: update the model at the edge, apply new inputs, return at negedge.
  task automatic tick(input logic [1:0] r, input logic [3:0] w);
    sb_t e;
    @(posedge read_clk);
    #1;
    exp_dv = 2'b00;
    if (prev_fire) begin
      if (sb.size() != 0) begin
        e = sb.pop_front();
        exp_dv = e.id;
        exp_dout = e.data;
      end
      m_bin  = m_bin + 4'd1;
      m_pref = exp_grant[0];
    end
    m_empty = (to_gray(m_bin) == read_to_write_pointer);
`ifdef READ_LEVEL_EN
    exp_level = from_gray(read_to_write_pointer) - m_bin;
`endif
    req = r;
    read_to_write_pointer = w;
    @(negedge read_clk);
    prev_fire = (r != 2'b00) && !m_empty;
    if (!prev_fire)      exp_grant = 2'b00;
    else if (r == 2'b11) exp_grant = m_pref ? 2'b10 : 2'b01;
    else                 exp_grant = r;
    if (prev_fire) sb.push_back({exp_grant, mem[m_bin[2:0]]});
  endtask

  task automatic test_reset();
    read_reset_n = 1'b0; req = 2'b11; read_to_write_pointer = 4'd0;
    model_reset();
    repeat (3) @(negedge read_clk);
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", empty); end
    checks++; if (data_valid !== 2'b00) begin failures++; $display("FAIL rst_dv got=%b exp=00", data_valid); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rst_dout got=%h exp=00", data_out); end
    checks++; if (read_pointer !== 4'd0) begin failures++; $display("FAIL rst_rp got=%b exp=0000", read_pointer); end
    read_reset_n = 1'b1;
    repeat (10) begin
      tick(2'b11, 4'd0);
      checks++; if (empty !== 1'b1 || grant !== 2'b00 || data_valid !== 2'b00 || read_pointer !== 4'd0) begin
        failures++; $display("FAIL idle empty=%b grant=%b dv=%b rp=%b exp 1/00/00/0000", empty, grant, data_valid, read_pointer);
      end
    end
  endtask

  task automatic test_single();
    tick(2'b01, 4'b0001);
    checks++; if (empty !== 1'b1 || grant !== 2'b00) begin failures++; $display("FAIL single_wait empty=%b grant=%b exp 1/00", empty, grant); end
    tick(2'b01, 4'b0001);
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL single_empty got=%b exp=0", empty); end
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL single_grant got=%b exp=01", grant); end
    tick(2'b00, 4'b0001);
    checks++; if (data_valid !== 2'b01 || data_out !== 8'hA5) begin failures++; $display("FAIL single_data dv=%b dout=%h exp 01/a5", data_valid, data_out); end
    checks++; if (read_pointer !== 4'b0001 || empty !== 1'b1) begin failures++; $display("FAIL single_ptr rp=%b empty=%b exp 0001/1", read_pointer, empty); end
  endtask

  task automatic test_alternate();
    logic [3:0] w;
    logic [1:0] seq [4];
    int n = 0;
    w = to_gray(m_bin + 4'd4);
    repeat (8) begin
      tick(2'b11, w);
      checks++; if (grant !== exp_grant) begin failures++; $display("FAIL alt_grant got=%b exp=%b", grant, exp_grant); end
      checks++; if (data_valid !== exp_dv || (exp_dv != 2'b00 && data_out !== exp_dout)) begin
        failures++; $display("FAIL alt_data dv=%b dout=%h exp %b/%h", data_valid, data_out, exp_dv, exp_dout);
      end
      if (grant != 2'b00 && n < 4) begin seq[n] = grant; n++; end
    end
    checks++; if (n != 4 || seq[0] !== 2'b10 || seq[1] !== 2'b01 || seq[2] !== 2'b10 || seq[3] !== 2'b01) begin
      failures++; $display("FAIL alt_order count=%0d exp=4 with order 10,01,10,01", n);
    end
    checks++; if (empty !== 1'b1 || grant !== 2'b00) begin failures++; $display("FAIL alt_drained empty=%b grant=%b exp 1/00", empty, grant); end
  endtask

  task automatic test_wrap();
    logic [3:0] w, wbin, start;
    int writes, reads, cyc;
    start = m_bin;
    for (int lap = 0; lap < 2; lap++) begin
      writes = 0; reads = 0; cyc = 0;
      wbin = from_gray(read_to_write_pointer);
      w = read_to_write_pointer;
      while (reads < 8 && cyc < 200) begin
        if (writes < 8 && $urandom_range(0, 1) == 1) begin
          mem[wbin[2:0]] = 8'($urandom);
          wbin = wbin + 4'd1; w = to_gray(wbin); writes++;
        end
        tick(2'($urandom_range(0, 3)), w);
        if (prev_fire) reads++;
        cyc++;
        checks++; if (grant !== exp_grant || empty !== m_empty || read_pointer !== to_gray(m_bin)) begin
          failures++; $display("FAIL wrap_ctl grant=%b empty=%b rp=%b exp %b/%b/%b", grant, empty, read_pointer, exp_grant, m_empty, to_gray(m_bin));
        end
        checks++; if (data_valid !== exp_dv || (exp_dv != 2'b00 && data_out !== exp_dout)) begin
          failures++; $display("FAIL wrap_data dv=%b dout=%h exp %b/%h", data_valid, data_out, exp_dv, exp_dout);
        end
      end
      checks++; if (cyc >= 200) begin failures++; $display("FAIL wrap_timeout reads=%0d exp=8", reads); end
    end
    tick(2'b00, read_to_write_pointer);
    checks++; if (data_valid !== exp_dv || read_pointer !== to_gray(start)) begin
      failures++; $display("FAIL wrap_end dv=%b rp=%b exp %b/%b", data_valid, read_pointer, exp_dv, to_gray(start));
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] w;
    w = to_gray(m_bin + 4'd3);
    tick(2'b10, w);
    tick(2'b10, w);
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL mid_grant got=%b exp=10", grant); end
    tick(2'b00, w);
    checks++; if (data_valid !== 2'b10) begin failures++; $display("FAIL mid_dv_before got=%b exp=10", data_valid); end
    #2 read_reset_n = 1'b0;
    #1;
    checks++; if (data_valid !== 2'b00 || data_out !== 8'h00) begin failures++; $display("FAIL mid_clear dv=%b dout=%h exp 00/00", data_valid, data_out); end
    checks++; if (read_pointer !== 4'd0 || empty !== 1'b1) begin failures++; $display("FAIL mid_ptr rp=%b empty=%b exp 0000/1", read_pointer, empty); end
    model_reset();
    read_to_write_pointer = 4'd0; req = 2'b00;
    @(negedge read_clk);
    read_reset_n = 1'b1;
    repeat (3) begin
      tick(2'b11, 4'd0);
      checks++; if (empty !== 1'b1 || grant !== 2'b00 || data_valid !== 2'b00) begin
        failures++; $display("FAIL mid_after empty=%b grant=%b dv=%b exp 1/00/00", empty, grant, data_valid);
      end
    end
  endtask

`ifdef READ_LEVEL_EN
  task automatic test_level();
    checks++; if (read_level !== 4'd0) begin failures++; $display("FAIL level_rst got=%0d exp=0", read_level); end
    tick(2'b01, to_gray(4'd2));
    tick(2'b01, to_gray(4'd2));
    tick(2'b01, to_gray(4'd2));
    tick(2'b00, to_gray(4'd5));
    tick(2'b00, to_gray(4'd5));
    checks++; if (read_level !== 4'd3) begin failures++; $display("FAIL level_val got=%0d exp=3", read_level); end
    checks++; if (read_level !== exp_level) begin failures++; $display("FAIL level_model got=%0d exp=%0d", read_level, exp_level); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA5;
    test_reset();
    test_single();
    test_alternate();
    test_wrap();
    test_reset_mid();
`ifdef READ_LEVEL_EN
    test_level();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
